// File: rtl/pio_init_pkg.sv
// Shared types and constants for the DE0-Nano-SoC PIO initiator.
// The optional readback check is enabled with the PIO_INITIATOR_VERIFY_EN macro.
package pio_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_READ   = 3'd2,
    ST_RESP   = 3'd3,
    ST_VERIFY = 3'd4
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  addr;
    logic [31:0] data;
  } cmd_t;

  localparam logic [1:0]  RST_ADDR = 2'd0;
  localparam logic [31:0] RST_DATA = 32'd0;
  localparam cmd_t        RST_CMD  = '{write: 1'b0, addr: 2'd0, data: 32'd0};

  // Nonzero when any masked bit of the readback differs from the written value.
  function automatic logic verify_mismatch(input logic [31:0] rd,
                                           input logic [31:0] wd,
                                           input logic [31:0] mask);
    return |((rd ^ wd) & mask);
  endfunction

endpackage

// File: rtl/pio_init_cmd_fifo.sv
// Synchronous command FIFO for the PIO initiator; DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module pio_init_cmd_fifo
  import pio_init_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output logic full,
  output logic empty,
  output cmd_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign head      = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset flushes every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_CMD;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/de0_nano_soc_pio_initiator.sv
// Avalon-MM initiator for the single-bit PIO slaves: queued commands in,
// one zero-wait bus transfer per command, read data out on a response port.
// Define PIO_INITIATOR_VERIFY_EN to add a readback check after every write.
module de0_nano_soc_pio_initiator
  import pio_init_pkg::*;
#(
  parameter int          CMD_DEPTH = 4,
  parameter int          READ_WAIT = 1,
  parameter logic [31:0] DATA_MASK = 32'h1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        verify_err,
  input  logic        verify_clr,
  output logic [1:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);

  localparam int WW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  state_e        state_q, state_d;
  logic          cs_q, cs_d;
  logic          write_n_q, write_n_d;
  logic [1:0]    address_q, address_d;
  logic [31:0]   writedata_q, writedata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          verify_err_q, verify_err_d;
  logic          launch_s;
  logic          mismatch_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  cmd_t          fifo_head_s;
  cmd_t          cmd_in_s;

  assign cmd_in_s  = '{write: cmd_write, addr: cmd_addr, data: cmd_data};
  assign cmd_ready = !fifo_full_s;

  pio_init_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_valid && cmd_ready),
    .pop     (launch_s),
    .din     (cmd_in_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .head    (fifo_head_s)
  );

`ifndef PIO_INITIATOR_VERIFY_EN
  logic unused_s;
  assign unused_s = ^{verify_clr, DATA_MASK};
`endif

  // Transfer sequencing: decide next state and next registered bus/response values.
  always_comb begin
    state_d      = state_q;
    cs_d         = 1'b0;
    write_n_d    = 1'b1;
    address_d    = address_q;
    writedata_d  = writedata_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    wait_d       = wait_q;
    launch_s     = 1'b0;
    mismatch_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          launch_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
`ifdef PIO_INITIATOR_VERIFY_EN
        // Read the same address back one cycle after the write strobe.
        state_d   = ST_VERIFY;
        cs_d      = 1'b1;
        write_n_d = 1'b1;
`else
        if (!fifo_empty_s) begin
          launch_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_READ: begin
        if (wait_q == {WW{1'b0}}) begin
          rsp_data_d  = readdata;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          wait_d = wait_q - WW'(1);
          cs_d   = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      ST_VERIFY: begin
`ifdef PIO_INITIATOR_VERIFY_EN
        mismatch_s = verify_mismatch(readdata, writedata_q, DATA_MASK);
        if (!fifo_empty_s) begin
          launch_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Start the transfer for the FIFO head; the pop happens in this same cycle.
    if (launch_s) begin
      state_d     = fifo_head_s.write ? ST_WRITE : ST_READ;
      cs_d        = 1'b1;
      write_n_d   = !fifo_head_s.write;
      address_d   = fifo_head_s.addr;
      writedata_d = fifo_head_s.write ? fifo_head_s.data : writedata_q;
      wait_d      = WW'(READ_WAIT - 1);
    end else begin
      wait_d = wait_d;
    end
`ifdef PIO_INITIATOR_VERIFY_EN
    verify_err_d = verify_clr ? 1'b0 : (verify_err_q | mismatch_s);
`else
    verify_err_d = 1'b0;
`endif
  end

  // FSM and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cs_q         <= 1'b0;
      write_n_q    <= 1'b1;
      address_q    <= RST_ADDR;
      writedata_q  <= RST_DATA;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= RST_DATA;
      wait_q       <= {WW{1'b0}};
      verify_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cs_q         <= cs_d;
      write_n_q    <= write_n_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      wait_q       <= wait_d;
      verify_err_q <= verify_err_d;
    end
  end

  assign chipselect = cs_q;
  assign write_n    = write_n_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign verify_err = verify_err_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty_s;

endmodule
